// File: rtl/prio_heap_seq_if.sv
// Push/pop/top bundle between a heap user (master) and prio_heap_seq (slave).
// Latency: pure wiring, no state.
// Backpressure: in_ready gates pushes, top_valid gates pops; both are driven by the heap.
interface prio_heap_seq_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              pop;
  logic              top_valid;
  logic [DATA_W-1:0] top_data;
  logic [CNT_W-1:0]  count;
  logic              busy;

  modport master (
    output in_valid, in_data, pop,
    input  in_ready, top_valid, top_data, count, busy
  );

  modport slave (
    input  in_valid, in_data, pop,
    output in_ready, top_valid, top_data, count, busy
  );
endinterface

// File: rtl/prio_heap_seq.sv
// Binary-heap priority queue (max or min on top) with an iterative sift FSM, one tree level per cycle; HEAP_ERR_EN adds sticky err_ovf/err_udf flags with err_clr.
// Latency: push/pop accepted in the request cycle, then busy for at most floor(log2(count)) cycles.
// Backpressure: in_ready and top_valid are low while a sift runs; in_ready also low when full, top_valid low when empty.
module prio_heap_seq #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter bit MAX_HEAP = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  prio_heap_seq_if.slave hif
`ifdef HEAP_ERR_EN
  ,
  output logic           err_ovf,
  output logic           err_udf,
  input  logic           err_clr
`endif
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  // One extra bit so 2*idx+2 never wraps, even at DEPTH = 2**k.
  localparam int IDX_W = CNT_W + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

  // Strict ordering: equal keys never count as better, so they never swap.
  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (MAX_HEAP) return a > b;
    else          return a < b;
  endfunction

  logic [DATA_W-1:0] arr_q [DEPTH];
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Two write ports: a swap rewrites two entries in one cycle.
  logic              wa_en, wb_en;
  logic [AW-1:0]     wa_addr, wb_addr;
  logic [DATA_W-1:0] wa_dat, wb_dat;

  logic [IDX_W-1:0]  cnt_x, par_idx, lft_idx, rgt_idx, best_idx, best_lft;
  logic [DATA_W-1:0] cur_v, par_v, lft_v, rgt_v, best_v, last_v;
  logic              idle, push_acc, pop_acc;

  assign idle          = (state_q == IDLE);
  assign hif.in_ready  = !rst && idle && (count_q < CNT_W'(DEPTH));
  assign hif.top_valid = !rst && idle && (count_q != '0);
  assign hif.busy      = !idle;
  assign hif.top_data  = arr_q[0];
  assign hif.count     = count_q;
  assign push_acc      = hif.in_valid && hif.in_ready;
  assign pop_acc       = hif.pop && hif.top_valid;

  // Tree neighbourhood of the sift cursor and the best of node/left/right.
  always_comb begin
    cnt_x   = {1'b0, count_q};
    par_idx = (idx_q - IDX_W'(1)) >> 1;
    lft_idx = (idx_q << 1) + IDX_W'(1);
    rgt_idx = lft_idx + IDX_W'(1);
    cur_v   = arr_q[idx_q[AW-1:0]];
    par_v   = arr_q[par_idx[AW-1:0]];
    lft_v   = arr_q[lft_idx[AW-1:0]];
    rgt_v   = arr_q[rgt_idx[AW-1:0]];
    last_v  = arr_q[AW'(count_q - CNT_W'(1))];
    best_idx = idx_q;
    best_v   = cur_v;
    if ((lft_idx < cnt_x) && better(lft_v, best_v)) begin
      best_idx = lft_idx;
      best_v   = lft_v;
    end
    if ((rgt_idx < cnt_x) && better(rgt_v, best_v)) begin
      best_idx = rgt_idx;
      best_v   = rgt_v;
    end
    best_lft = (best_idx << 1) + IDX_W'(1);
  end

  // Next state, occupancy, cursor and array writes for accept and sift steps.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    wa_en   = 1'b0;
    wa_addr = '0;
    wa_dat  = '0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_dat  = '0;
    unique case (state_q)
      IDLE: begin
        if (push_acc && pop_acc) begin
          // Replace-top: new key lands on the root and sinks.
          wa_en   = 1'b1;
          wa_addr = '0;
          wa_dat  = hif.in_data;
          idx_d   = '0;
          state_d = SIFT_DOWN;
        end else if (push_acc) begin
          wa_en   = 1'b1;
          wa_addr = AW'(count_q);
          wa_dat  = hif.in_data;
          count_d = count_q + CNT_W'(1);
          idx_d   = IDX_W'(count_q);
          state_d = (count_q == '0) ? IDLE : SIFT_UP;
        end else if (pop_acc) begin
          wa_en   = 1'b1;
          wa_addr = '0;
          wa_dat  = last_v;
          count_d = count_q - CNT_W'(1);
          idx_d   = '0;
          state_d = (count_q <= CNT_W'(2)) ? IDLE : SIFT_DOWN;
        end
      end
      SIFT_UP: begin
        if (idx_q == '0) begin
          state_d = IDLE;
        end else if (better(cur_v, par_v)) begin
          wa_en   = 1'b1;
          wa_addr = idx_q[AW-1:0];
          wa_dat  = par_v;
          wb_en   = 1'b1;
          wb_addr = par_idx[AW-1:0];
          wb_dat  = cur_v;
          idx_d   = par_idx;
          // Reaching the root ends the sift now instead of spending a check cycle.
          if (par_idx == '0) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      SIFT_DOWN: begin
        if (best_idx != idx_q) begin
          wa_en   = 1'b1;
          wa_addr = idx_q[AW-1:0];
          wa_dat  = best_v;
          wb_en   = 1'b1;
          wb_addr = best_idx[AW-1:0];
          wb_dat  = cur_v;
          idx_d   = best_idx;
          // Landing on a leaf ends the sift now instead of spending a check cycle.
          if (best_lft >= cnt_x) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, occupancy and sift cursor; reset aborts any sift and empties the heap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  // Key storage; only the root is reset so top_data reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_q[0] <= '0;
    end else begin
      if (wa_en) arr_q[wa_addr] <= wa_dat;
      if (wb_en) arr_q[wb_addr] <= wb_dat;
    end
  end

`ifdef HEAP_ERR_EN
  logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

  // Sticky protocol errors; a fresh error in the clear cycle keeps the flag set.
  always_comb begin
    err_ovf_d = (err_ovf_q && !err_clr) || (idle && hif.in_valid && (count_q == CNT_W'(DEPTH)));
    err_udf_d = (err_udf_q && !err_clr) || (idle && hif.pop && (count_q == '0));
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`endif
endmodule

// File: tb/tb_prio_heap_seq.sv
// Bench for prio_heap_seq: a 1024-deep max-heap (sel 0) and an 8-deep min-heap (sel 1) against queue models.
// Latency: each op waits for busy to fall, bounded per op and by a global watchdog.
// Backpressure: pushes/pops are offered only while the DUT is idle; full/empty drops are modelled.
module tb_prio_heap_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, rst_s;
  prio_heap_seq_if #(.DATA_W(32), .DEPTH(1024)) if_b ();
  prio_heap_seq_if #(.DATA_W(32), .DEPTH(8))    if_s ();
`ifdef HEAP_ERR_EN
  logic ovf_b, udf_b, clr_b, ovf_s, udf_s, clr_s;
`endif

  prio_heap_seq #(.DATA_W(32), .DEPTH(1024), .MAX_HEAP(1'b1)) u_big (
    .clk(clk), .rst(rst_b), .hif(if_b)
`ifdef HEAP_ERR_EN
    , .err_ovf(ovf_b), .err_udf(udf_b), .err_clr(clr_b)
`endif
  );

  prio_heap_seq #(.DATA_W(32), .DEPTH(8), .MAX_HEAP(1'b0)) u_small (
    .clk(clk), .rst(rst_s), .hif(if_s)
`ifdef HEAP_ERR_EN
    , .err_ovf(ovf_s), .err_udf(udf_s), .err_clr(clr_s)
`endif
  );

  int unsigned q_b[$];
  int unsigned q_s[$];
  int vec_n = 0;
  int miss_n = 0;

  // ---------------- reference model: plain multisets ----------------
  function automatic int unsigned m_size(input bit s);
    return s ? q_s.size() : q_b.size();
  endfunction

  function automatic int unsigned m_depth(input bit s);
    return s ? 8 : 1024;
  endfunction

  // Largest key for the max-heap, smallest for the min-heap.
  function automatic int unsigned m_top(input bit s);
    int unsigned t;
    t = 0;
    if (s) begin
      if (q_s.size() != 0) t = q_s[0];
      foreach (q_s[i]) if (q_s[i] < t) t = q_s[i];
    end else begin
      foreach (q_b[i]) if (q_b[i] > t) t = q_b[i];
    end
    return t;
  endfunction

  task automatic m_del_top(input bit s);
    int unsigned t;
    t = m_top(s);
    if (s) begin
      foreach (q_s[i]) if (q_s[i] == t) begin q_s.delete(i); return; end
    end else begin
      foreach (q_b[i]) if (q_b[i] == t) begin q_b.delete(i); return; end
    end
  endtask

  task automatic m_apply(input bit s, input bit pv, input int unsigned pd, input bit pp);
    bit pa, qa;
    pa = pv && (m_size(s) < m_depth(s));
    qa = pp && (m_size(s) != 0);
    if (qa) m_del_top(s);
    if (pa) begin
      if (s) q_s.push_back(pd);
      else   q_b.push_back(pd);
    end
  endtask

  function automatic int flog2(input int unsigned n);
    int r;
    r = 0;
    while (n > 1) begin n = n >> 1; r++; end
    return r;
  endfunction

  // ---------------- DUT accessors ----------------
  function automatic int unsigned d_top(input bit s);
    return s ? if_s.top_data : if_b.top_data;
  endfunction
  function automatic int unsigned d_cnt(input bit s);
    return s ? 32'(if_s.count) : 32'(if_b.count);
  endfunction
  function automatic logic d_tv(input bit s);
    return s ? if_s.top_valid : if_b.top_valid;
  endfunction
  function automatic logic d_rdy(input bit s);
    return s ? if_s.in_ready : if_b.in_ready;
  endfunction
  function automatic logic d_busy(input bit s);
    return s ? if_s.busy : if_b.busy;
  endfunction

  // One request cycle, then wait (bounded) for the sift to finish; cyc = busy cycles seen.
  task automatic do_op(input bit s, input bit pv, input logic [31:0] pd, input bit pp, output int cyc);
    @(negedge clk);
    if (s) begin if_s.in_valid = pv; if_s.in_data = pd; if_s.pop = pp; end
    else   begin if_b.in_valid = pv; if_b.in_data = pd; if_b.pop = pp; end
    @(posedge clk); #1;
    if (s) begin if_s.in_valid = 1'b0; if_s.pop = 1'b0; end
    else   begin if_b.in_valid = 1'b0; if_b.pop = 1'b0; end
    m_apply(s, pv, pd, pp);
    cyc = 0;
    while (d_busy(s) && cyc < 64) begin @(posedge clk); #1; cyc++; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_b = 1'b1; rst_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      vec_n++; if (d_cnt(k[0]) !== 0) begin miss_n++; $display("FAIL reset_count[%0d] dut=%0d exp=0", k, d_cnt(k[0])); end
      vec_n++; if (d_busy(k[0]) !== 1'b0) begin miss_n++; $display("FAIL reset_busy[%0d] dut=%b exp=0", k, d_busy(k[0])); end
      vec_n++; if (d_tv(k[0]) !== 1'b0) begin miss_n++; $display("FAIL reset_top_valid[%0d] dut=%b exp=0", k, d_tv(k[0])); end
      vec_n++; if (d_top(k[0]) !== 0) begin miss_n++; $display("FAIL reset_top_data[%0d] dut=%0d exp=0", k, d_top(k[0])); end
      vec_n++; if (d_rdy(k[0]) !== 1'b0) begin miss_n++; $display("FAIL reset_in_ready_during[%0d] dut=%b exp=0", k, d_rdy(k[0])); end
    end
    @(negedge clk); rst_b = 1'b0; rst_s = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      vec_n++; if (d_rdy(k[0]) !== 1'b1) begin miss_n++; $display("FAIL reset_in_ready_after[%0d] dut=%b exp=1", k, d_rdy(k[0])); end
    end
  endtask

  task automatic test_max_basic();
    int cyc;
    int unsigned keys[4];
    int unsigned drain[4];
    keys  = '{5, 9, 1, 7};
    drain = '{9, 7, 5, 1};
    foreach (keys[i]) do_op(1'b0, 1'b1, keys[i], 1'b0, cyc);
    vec_n++; if (d_cnt(0) !== 4) begin miss_n++; $display("FAIL max_count dut=%0d exp=4", d_cnt(0)); end
    vec_n++; if (d_top(0) !== 9) begin miss_n++; $display("FAIL max_top dut=%0d exp=9", d_top(0)); end
    foreach (drain[i]) begin
      vec_n++; if (d_top(0) !== drain[i] || d_tv(0) !== 1'b1) begin miss_n++; $display("FAIL max_drain[%0d] dut=%0d/%b exp=%0d/1", i, d_top(0), d_tv(0), drain[i]); end
      do_op(1'b0, 1'b0, 32'd0, 1'b1, cyc);
    end
    vec_n++; if (d_tv(0) !== 1'b0) begin miss_n++; $display("FAIL max_empty_tv dut=%b exp=0", d_tv(0)); end
  endtask

  task automatic test_min_basic();
    int cyc;
    int unsigned keys[4];
    keys = '{8, 3, 6, 3};
    foreach (keys[i]) do_op(1'b1, 1'b1, keys[i], 1'b0, cyc);
    vec_n++; if (d_top(1) !== 3) begin miss_n++; $display("FAIL min_top0 dut=%0d exp=3", d_top(1)); end
    do_op(1'b1, 1'b0, 32'd0, 1'b1, cyc);
    vec_n++; if (d_top(1) !== 3) begin miss_n++; $display("FAIL min_top1 dut=%0d exp=3", d_top(1)); end
    do_op(1'b1, 1'b0, 32'd0, 1'b1, cyc);
    vec_n++; if (d_top(1) !== 6) begin miss_n++; $display("FAIL min_top2 dut=%0d exp=6", d_top(1)); end
    vec_n++; if (d_cnt(1) !== 2) begin miss_n++; $display("FAIL min_count dut=%0d exp=2", d_cnt(1)); end
    repeat (2) do_op(1'b1, 1'b0, 32'd0, 1'b1, cyc);
    vec_n++; if (d_cnt(1) !== 0) begin miss_n++; $display("FAIL min_drained dut=%0d exp=0", d_cnt(1)); end
  endtask

  task automatic test_fill();
    int cyc;
    for (int k = 1; k <= 8; k++) do_op(1'b1, 1'b1, 32'(k), 1'b0, cyc);
    vec_n++; if (d_rdy(1) !== 1'b0) begin miss_n++; $display("FAIL fill_in_ready dut=%b exp=0", d_rdy(1)); end
    vec_n++; if (d_cnt(1) !== 8) begin miss_n++; $display("FAIL fill_count dut=%0d exp=8", d_cnt(1)); end
    vec_n++; if (d_top(1) !== 1) begin miss_n++; $display("FAIL fill_top dut=%0d exp=1", d_top(1)); end
    do_op(1'b1, 1'b1, 32'd99, 1'b0, cyc);
    vec_n++; if (d_cnt(1) !== 8 || d_top(1) !== 1) begin miss_n++; $display("FAIL fill_overflow dut=%0d/%0d exp=8/1", d_cnt(1), d_top(1)); end
`ifdef HEAP_ERR_EN
    vec_n++; if (ovf_s !== 1'b1) begin miss_n++; $display("FAIL err_ovf_set dut=%b exp=1", ovf_s); end
    @(negedge clk); clr_s = 1'b1;
    @(posedge clk); #1; clr_s = 1'b0;
    vec_n++; if (ovf_s !== 1'b0) begin miss_n++; $display("FAIL err_ovf_clr dut=%b exp=0", ovf_s); end
`endif
    for (int k = 1; k <= 8; k++) begin
      vec_n++; if (d_top(1) !== 32'(k)) begin miss_n++; $display("FAIL fill_drain[%0d] dut=%0d exp=%0d", k, d_top(1), k); end
      do_op(1'b1, 1'b0, 32'd0, 1'b1, cyc);
    end
    vec_n++; if (d_tv(1) !== 1'b0) begin miss_n++; $display("FAIL fill_empty_tv dut=%b exp=0", d_tv(1)); end
  endtask

  task automatic test_replace();
    int cyc;
    do_op(1'b0, 1'b1, 32'd9, 1'b0, cyc);
    do_op(1'b0, 1'b1, 32'd7, 1'b0, cyc);
    do_op(1'b0, 1'b1, 32'd5, 1'b0, cyc);
    do_op(1'b0, 1'b1, 32'd6, 1'b1, cyc);
    vec_n++; if (d_cnt(0) !== 3) begin miss_n++; $display("FAIL replace_count dut=%0d exp=3", d_cnt(0)); end
    vec_n++; if (d_top(0) !== 7) begin miss_n++; $display("FAIL replace_top dut=%0d exp=7", d_top(0)); end
    vec_n++; if (cyc > 1) begin miss_n++; $display("FAIL replace_busy dut=%0d exp<=1", cyc); end
    do_op(1'b0, 1'b0, 32'd0, 1'b1, cyc);
    vec_n++; if (d_top(0) !== 6) begin miss_n++; $display("FAIL replace_next dut=%0d exp=6", d_top(0)); end
    repeat (2) do_op(1'b0, 1'b0, 32'd0, 1'b1, cyc);
  endtask

  task automatic test_empty_pop();
    int cyc;
    do_op(1'b0, 1'b0, 32'd0, 1'b1, cyc);
    vec_n++; if (d_cnt(0) !== 0 || d_tv(0) !== 1'b0 || d_busy(0) !== 1'b0) begin miss_n++; $display("FAIL empty_pop dut=%0d/%b/%b exp=0/0/0", d_cnt(0), d_tv(0), d_busy(0)); end
`ifdef HEAP_ERR_EN
    vec_n++; if (udf_b !== 1'b1) begin miss_n++; $display("FAIL err_udf_set dut=%b exp=1", udf_b); end
    @(negedge clk); clr_b = 1'b1;
    @(posedge clk); #1; clr_b = 1'b0;
    vec_n++; if (udf_b !== 1'b0) begin miss_n++; $display("FAIL err_udf_clr dut=%b exp=0", udf_b); end
`endif
  endtask

  task automatic test_random();
    int cyc, bound;
    bit s, pv, pp;
    int unsigned r, key;
    for (int n = 0; n < 400; n++) begin
      s   = 1'($urandom_range(0, 1));
      r   = $urandom_range(0, 9);
      key = $urandom_range(0, 50);
      pv  = (r < 5) || (r >= 8);
      pp  = (r >= 5);
      do_op(s, pv, key, pp, cyc);
      bound = flog2(m_size(s));
      if (bound < 1) bound = 1;
      vec_n++; if (d_cnt(s) !== m_size(s)) begin miss_n++; $display("FAIL rnd_count[%0d] dut=%0d exp=%0d", n, d_cnt(s), m_size(s)); end
      vec_n++; if (d_tv(s) !== (m_size(s) != 0)) begin miss_n++; $display("FAIL rnd_top_valid[%0d] dut=%b exp=%b", n, d_tv(s), m_size(s) != 0); end
      if (m_size(s) != 0) begin
        vec_n++; if (d_top(s) !== m_top(s)) begin miss_n++; $display("FAIL rnd_top[%0d] sel=%0d dut=%0d exp=%0d", n, s, d_top(s), m_top(s)); end
      end
      vec_n++; if (d_rdy(s) !== (m_size(s) < m_depth(s))) begin miss_n++; $display("FAIL rnd_in_ready[%0d] dut=%b exp=%b", n, d_rdy(s), m_size(s) < m_depth(s)); end
      vec_n++; if (cyc > bound) begin miss_n++; $display("FAIL rnd_busy[%0d] dut=%0d exp<=%0d", n, cyc, bound); end
    end
    // Empty both heaps again via the model-checked pop path.
    while (q_b.size() != 0) do_op(1'b0, 1'b0, 32'd0, 1'b1, cyc);
    while (q_s.size() != 0) do_op(1'b1, 1'b0, 32'd0, 1'b1, cyc);
    vec_n++; if (d_cnt(0) !== 0 || d_cnt(1) !== 0) begin miss_n++; $display("FAIL rnd_drained dut=%0d/%0d exp=0/0", d_cnt(0), d_cnt(1)); end
  endtask

  task automatic test_deep_reset();
    int cyc, worst;
    worst = 0;
    for (int k = 0; k < 1024; k++) begin
      do_op(1'b0, 1'b1, 32'(5000 - k), 1'b0, cyc);
      if (cyc > worst) worst = cyc;
    end
    vec_n++; if (worst > 10) begin miss_n++; $display("FAIL deep_push_busy dut=%0d exp<=10", worst); end
    vec_n++; if (d_cnt(0) !== 1024 || d_rdy(0) !== 1'b0) begin miss_n++; $display("FAIL deep_full dut=%0d/%b exp=1024/0", d_cnt(0), d_rdy(0)); end
    vec_n++; if (d_top(0) !== 5000) begin miss_n++; $display("FAIL deep_top dut=%0d exp=5000", d_top(0)); end
    @(negedge clk); if_b.pop = 1'b1;
    @(posedge clk); #1; if_b.pop = 1'b0;
    vec_n++; if (d_busy(0) !== 1'b1) begin miss_n++; $display("FAIL deep_sift_busy dut=%b exp=1", d_busy(0)); end
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;
    vec_n++; if (d_cnt(0) !== 0 || d_busy(0) !== 1'b0 || d_tv(0) !== 1'b0) begin miss_n++; $display("FAIL deep_reset dut=%0d/%b/%b exp=0/0/0", d_cnt(0), d_busy(0), d_tv(0)); end
    @(negedge clk); rst_b = 1'b0;
    q_b.delete();
  endtask

  initial begin
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.pop = 1'b0;
    if_s.in_valid = 1'b0; if_s.in_data = '0; if_s.pop = 1'b0;
`ifdef HEAP_ERR_EN
    clr_b = 1'b0; clr_s = 1'b0;
`endif
    test_reset();
    test_max_basic();
    test_min_basic();
    test_fill();
    test_replace();
    test_empty_pop();
    test_random();
    test_deep_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired vectors=%0d miscompares=%0d", vec_n, miss_n);
    $fatal(1, "watchdog");
  end
endmodule
